seven_seg_scan_controller: RTL
==============================

SEVEN_SEG_SCAN_CONTROLLER -- requirements
Module: seven_seg_scan_controller

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range 4..2^20.
REQ-002 Parameter BLANK_CYCLES, default 1000: anode-off guard cycles at the start of each slot; 1 <= BLANK_CYCLES < REFRESH_DIV.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 enable  input  1  1 = scan digits; 0 = display dark, scan counters held.
REQ-006 load  input  1  request to accept value_in/dp_in; accepted only when ready=1.
REQ-007 value_in  input  16  four BCD digits; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3.
REQ-008 dp_in  input  4  active-high decimal point per digit; bit k = digit k.
REQ-009 blank_lz  input  1  1 = suppress leading zeros.
REQ-010 an  output  4  active-low digit anodes; an[k] drives digit k.
REQ-011 seg  output  7  active-low segments, order {g,f,e,d,c,b,a}.
REQ-012 dp  output  1  active-low decimal point.
REQ-013 ready  output  1  1 = pending buffer empty, load will be accepted.
REQ-014 load_ack  output  1  one-cycle pulse confirming an accepted load.

Function
REQ-015 Two-stage buffering: pend_reg (value+dp) written by load, disp_reg (value+dp) drives the display; the display never reads pend_reg directly.
REQ-016 Load accepted in a cycle with load=1 and ready=1: pend_reg <= {value_in, dp_in}, pending <= 1, load_ack = 1 in the following cycle; load with ready=0 is ignored, no ack.
REQ-017 ready = ~pending, combinational from the pending register.
REQ-018 Transfer pend_reg -> disp_reg and clear pending at a frame boundary: enable=1, digit index 3, slot counter = REFRESH_DIV-1; with enable=0, transfer occurs in the first cycle pending=1.
REQ-019 Load and transfer in the same cycle: transfer uses the old pend_reg; the load is ignored (ready was 0).
REQ-020 Slot counter counts 0..REFRESH_DIV-1 while enable=1 then wraps to 0 and advances digit index 0->1->2->3->0.
REQ-021 States: OFF (enable=0), BLANK (slot counter < BLANK_CYCLES), SHOW (otherwise); OFF->BLANK with index 0 and counter 0 on the first enable=1 cycle.
REQ-022 OFF: counters cleared to 0 and held; an=4'b1111, seg=7'b1111111, dp=1.
REQ-023 BLANK: an=4'b1111, seg=7'b1111111, dp=1.
REQ-024 SHOW: an = all ones except bit[index]=0; seg = decode of disp_reg digit[index]; dp = ~dp bit[index].
REQ-025 Decode active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; codes 10-15 show dash 0111111.
REQ-026 Leading-zero suppress: with blank_lz=1, digit k (k=1..3) shows seg=1111111 when digits k..3 of disp_reg are all 0; digit 0 is never suppressed; anode and dp still driven per REQ-024.
REQ-027 an, seg, dp are registered: they reflect the counter/index/state of the previous cycle (one-cycle latency).
REQ-028 enable dropping mid-slot: next cycle outputs go dark per REQ-022; no partial-slot memory.

Reset
REQ-029 rst_n=0 at a clock edge: disp_reg=0, pend_reg=0, pending=0, counters=0, state OFF; next cycle an=4'b1111, seg=7'b1111111, dp=1, ready=1, load_ack=0.
REQ-030 Reset overrides load, transfer and enable in the same cycle; reset mid-slot discards any pending value.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-031 Reset, enable=1, load value_in=16'h1234 dp_in=0 -> load_ack once, ready=0 until frame end; after transfer digits scan 4,3,2,1 on an=1110,1101,1011,0111 with seg 0011001,0110000,0100100,1111001.
REQ-032 Slot timing: per slot, an=1111 for 2 cycles then one active anode for 6 cycles; index 3 wraps to 0.
REQ-033 blank_lz=1, display 16'h0005 -> digits 3..1 seg=1111111, digit 0 seg=0010010; value 16'h0000 -> digit 0 shows 1000000.
REQ-034 Load 16'h9999 mid-frame then load 16'h1111 before boundary -> second load unacked; display changes to 9999 only after index 3 slot ends.
REQ-035 value_in=16'hF0A0, dp_in=4'b0100 -> digits 3 and 1 show 0111111, dp=0 only while an=1011.
REQ-036 rst_n=0 during SHOW with pending=1 -> next cycle all outputs dark, ready=1, old display value gone (digit 0 shows 1000000 once enabled).

Source files
------------

// File: rtl/seven_seg_scan_controller.sv
// rtl/seven_seg_scan_controller.sv - four-digit multiplexed seven-segment scanner with double-buffered value
module seven_seg_scan_controller #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        ready,
    output logic        load_ack
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    logic [15:0]     pend_val;
    logic [3:0]      pend_dp;
    logic [15:0]     disp_val;
    logic [3:0]      disp_dp;
    logic            pending;

    logic            frame_end;
    logic            transfer;
    logic            accept;
    logic [3:0]      cur_digit;
    logic            lz_blank;
    logic [CW-1:0]   cnt_inc;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    assign ready     = ~pending;
    assign frame_end = (state != ST_OFF) && (idx == 2'd3) && (cnt == SLOT_LAST);
    // While dark there is no frame to tear, so a pending value moves over at once.
    assign transfer  = pending && (enable ? frame_end : 1'b1);
    assign accept    = load && !pending;
    assign cur_digit = disp_val[{idx, 2'b00} +: 4];
    assign cnt_inc   = cnt + CW'(1);

    always_comb begin
        lz_blank = 1'b0;
        if (blank_lz) begin
            case (idx)
                2'd1:    lz_blank = (disp_val[15:4] == 12'd0);
                2'd2:    lz_blank = (disp_val[15:8] == 8'd0);
                2'd3:    lz_blank = (disp_val[15:12] == 4'd0);
                default: lz_blank = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_OFF;
            cnt      <= '0;
            idx      <= 2'd0;
            pend_val <= 16'd0;
            pend_dp  <= 4'd0;
            disp_val <= 16'd0;
            disp_dp  <= 4'd0;
            pending  <= 1'b0;
            load_ack <= 1'b0;
            an       <= 4'b1111;
            seg      <= 7'b1111111;
            dp       <= 1'b1;
        end else begin
            load_ack <= accept;
            if (transfer) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
                pending  <= 1'b0;
            end else if (accept) begin
                pend_val <= value_in;
                pend_dp  <= dp_in;
                pending  <= 1'b1;
            end

            if (!enable) begin
                state <= ST_OFF;
                cnt   <= '0;
                idx   <= 2'd0;
            end else if (state == ST_OFF || cnt == SLOT_LAST) begin
                state <= ST_BLANK;
                cnt   <= '0;
                idx   <= (state == ST_OFF) ? 2'd0 : idx + 2'd1;
            end else begin
                cnt   <= cnt_inc;
                state <= (cnt_inc < BLANK_END) ? ST_BLANK : ST_SHOW;
            end

            // Outputs lag the scan state by one cycle; dropping enable darkens them immediately.
            if (!enable || state != ST_SHOW) begin
                an  <= 4'b1111;
                seg <= 7'b1111111;
                dp  <= 1'b1;
            end else begin
                an  <= ~(4'b0001 << idx);
                seg <= lz_blank ? 7'b1111111 : decode(cur_digit);
                dp  <= ~disp_dp[idx];
            end
        end
    end

endmodule
